// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the fetch stage and its instruction queue.
package if_pkg;

  localparam int IF_XLEN    = 64;
  localparam int INST_BYTES = 4;
  localparam int LINE_BYTES = 8;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [31:0]        inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_STALL = 2'd1,
    IF_HALT  = 2'd2
  } if_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular buffer of fetch entries: 2-wide write, 1-wide read, synchronous flush.
module fetch_queue
  import if_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic [1:0]   i_wr_n,
  input  fetch_entry_t i_wr_data0,
  input  fetch_entry_t i_wr_data1,
  input  logic         i_rd_en,
  output fetch_entry_t o_rd_data,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Storage is not reset; only the pointers and count define what is live.
  always_ff @(posedge i_clk) begin
    if (!i_flush) begin
      if (i_wr_n != 2'd0) r_mem[r_tail] <= i_wr_data0;
      if (i_wr_n == 2'd2) r_mem[r_tail + PW'(1)] <= i_wr_data1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PW'(i_wr_n);
      r_head  <= r_head + PW'(i_rd_en);
      r_count <= r_count + CW'(i_wr_n) - CW'(i_rd_en);
    end
  end

  assign o_rd_data = r_mem[r_head];
  assign o_count   = r_count;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch PC, fetch FSM and line split feeding decode through fetch_queue.
// Optional FQ_BYPASS_EN: an accepted line reaches if_* in the same cycle when the queue is empty.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter  int FQ_DEPTH = 8,
  parameter  int XLEN     = IF_XLEN,
  localparam int CW       = $clog2(FQ_DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] proc2Icache_addr,
  input  logic [63:0]     Icache_data_out,
  input  logic            Icache_valid_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  input  logic            dec_ready,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [CW-1:0]   fq_count
);

  logic [XLEN-1:0] r_fetch_pc;
  if_state_t       r_state;
  if_state_t       w_state_next;

  logic [CW-1:0]   w_q_count;
  fetch_entry_t    w_head;
  logic            w_q_valid;
  logic            w_deq_q;
  logic [CW-1:0]   w_free;
  logic [CW-1:0]   w_need;
  logic            w_space;
  logic            w_accept;
  logic [XLEN-1:0] w_pc_plus4;
  fetch_entry_t    w_e0;
  fetch_entry_t    w_e1;
  logic [1:0]      w_wr_n;
  fetch_entry_t    w_wr0;
  logic            w_unused_redirect_lo;

  assign w_unused_redirect_lo = ^redirect_pc[1:0];

  assign w_q_valid  = (w_q_count != '0);
  assign w_deq_q    = w_q_valid && dec_ready;
  // A same-cycle dequeue frees a slot for the incoming line.
  assign w_free     = CW'(FQ_DEPTH) - w_q_count + CW'(w_deq_q);
  assign w_need     = r_fetch_pc[2] ? CW'(1) : CW'(2);
  assign w_space    = (w_free >= w_need);
  assign w_accept   = (r_state == IF_FETCH) && Icache_valid_out && w_space && !redirect_valid;
  assign w_pc_plus4 = r_fetch_pc + XLEN'(INST_BYTES);

  always_comb begin
    w_e0.pc   = IF_XLEN'(r_fetch_pc);
    w_e0.inst = r_fetch_pc[2] ? Icache_data_out[63:32] : Icache_data_out[31:0];
    w_e1.pc   = IF_XLEN'(w_pc_plus4);
    w_e1.inst = Icache_data_out[63:32];
  end

  always_comb begin
    w_wr_n   = 2'd0;
    w_wr0    = w_e0;
    if_valid = w_q_valid;
    if_inst  = w_q_valid ? w_head.inst : 32'd0;
    if_pc    = w_q_valid ? XLEN'(w_head.pc) : '0;
    if (w_accept) w_wr_n = r_fetch_pc[2] ? 2'd1 : 2'd2;
`ifdef FQ_BYPASS_EN
    if (w_accept && !w_q_valid) begin
      if_valid = 1'b1;
      if_inst  = w_e0.inst;
      if_pc    = XLEN'(w_e0.pc);
      if (dec_ready) begin
        w_wr_n = w_wr_n - 2'd1;
        w_wr0  = w_e1;
      end
    end
`endif
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_queue (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_flush    (redirect_valid),
    .i_wr_n     (w_wr_n),
    .i_wr_data0 (w_wr0),
    .i_wr_data1 (w_e1),
    .i_rd_en    (w_deq_q),
    .o_rd_data  (w_head),
    .o_count    (w_q_count)
  );

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = IF_FETCH;
    end else if (halt) begin
      w_state_next = IF_HALT;
    end else begin
      case (r_state)
        IF_FETCH: if (!w_space) w_state_next = IF_STALL;
        IF_STALL: if (w_space)  w_state_next = IF_FETCH;
        default:  w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= '0;
      r_state    <= IF_FETCH;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc[2] ? w_pc_plus4 : r_fetch_pc + XLEN'(LINE_BYTES);
    end
  end

  assign proc2Icache_addr = r_fetch_pc;
  assign fq_count         = w_q_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed bench with a scoreboard of expected {pc, inst} entries.
module tb_if_fetch_queue;

  localparam int DEPTH = 8;
  localparam int XL    = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [XL-1:0] proc2Icache_addr;
  logic [63:0]   Icache_data_out;
  logic          Icache_valid_out = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [XL-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          dec_ready = 1'b0;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [XL-1:0] if_pc;
  logic [CW-1:0] fq_count;
  logic          const_line = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_pc;
  int          m_state;
  logic [63:0] m_pcq[$];
  logic [31:0] m_iq[$];

  if_fetch_queue #(.FQ_DEPTH(DEPTH), .XLEN(XL)) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2Icache_addr (proc2Icache_addr),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt             (halt),
    .dec_ready        (dec_ready),
    .if_valid         (if_valid),
    .if_inst          (if_inst),
    .if_pc            (if_pc),
    .fq_count         (fq_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A00_0000;
  endfunction

  assign Icache_data_out = const_line ? 64'h00000013_00000093
                         : {inst_of(proc2Icache_addr | 64'h4), inst_of(proc2Icache_addr & ~64'h7)};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_state = 0;
    m_pcq.delete();
    m_iq.delete();
  endtask

  // Called at a negedge: check outputs, advance the model across the next posedge.
  task automatic tick();
    int          sz, free, need;
    bit          deq, acc, space;
    logic [31:0] lo, hi;
    #1;
    sz = m_pcq.size();
    chk("addr", 64'(proc2Icache_addr), m_pc);
    chk("count", 64'(fq_count), 64'(sz));
    chk("valid", 64'(if_valid), 64'(sz != 0));
    if (sz != 0) begin
      chk("if_pc", 64'(if_pc), m_pcq[0]);
      chk("if_inst", 64'(if_inst), 64'(m_iq[0]));
    end
    deq   = (sz != 0) && dec_ready;
    free  = DEPTH - sz + int'(deq);
    need  = m_pc[2] ? 1 : 2;
    space = (free >= need);
    acc   = (m_state == 0) && Icache_valid_out && space && !redirect_valid;
    lo    = const_line ? 32'h00000093 : inst_of(m_pc & ~64'h7);
    hi    = const_line ? 32'h00000013 : inst_of(m_pc | 64'h4);
    if (deq) begin
      void'(m_pcq.pop_front());
      void'(m_iq.pop_front());
    end
    if (redirect_valid) begin
      m_pcq.delete();
      m_iq.delete();
      m_pc    = {redirect_pc[63:2], 2'b00};
      m_state = 0;
    end else begin
      if (acc) begin
        if (m_pc[2]) begin
          m_pcq.push_back(m_pc);
          m_iq.push_back(hi);
          m_pc = m_pc + 64'd4;
        end else begin
          m_pcq.push_back(m_pc);
          m_iq.push_back(lo);
          m_pcq.push_back(m_pc + 64'd4);
          m_iq.push_back(hi);
          m_pc = m_pc + 64'd8;
        end
      end
      if (halt) m_state = 2;
      else if (m_state == 0 && !space) m_state = 1;
      else if (m_state == 1 && space) m_state = 0;
    end
    @(negedge clock);
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    #1;
    chk("rst_addr", 64'(proc2Icache_addr), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_count", 64'(fq_count), 64'd0);
    chk("rst_inst", 64'(if_inst), 64'd0);
    chk("rst_pc", 64'(if_pc), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // 1: constant line streaming
    Icache_valid_out = 1'b1;
    dec_ready = 1'b1;
    tick();
    chk("t1_inst0", 64'(if_inst), 64'h93);
    chk("t1_addr8", 64'(proc2Icache_addr), 64'h8);
    repeat (16) tick();

    // 2: decode blocked, queue saturates
    const_line = 1'b0;
    dec_ready  = 1'b0;
    do_redirect(64'h0);
    repeat (20) tick();
    chk("t2_count", 64'(fq_count), 64'd8);
    chk("t2_addr", 64'(proc2Icache_addr), 64'h20);

    // 3: drain to 5 then redirect to 0x104
    Icache_valid_out = 1'b0;
    dec_ready = 1'b1;
    repeat (3) tick();
    chk("t3_count5", 64'(fq_count), 64'd5);
    Icache_valid_out = 1'b1;
    do_redirect(64'h104);
    dec_ready = 1'b0;
    chk("t3_count0", 64'(fq_count), 64'd0);
    chk("t3_valid0", 64'(if_valid), 64'd0);
    chk("t3_addr", 64'(proc2Icache_addr), 64'h104);
    tick();
    chk("t3_count1", 64'(fq_count), 64'd1);
    chk("t3_addr2", 64'(proc2Icache_addr), 64'h108);
    chk("t3_pc", 64'(if_pc), 64'h104);
    chk("t3_inst", 64'(if_inst), 64'(inst_of(64'h104)));

    // 4: cache miss window
    dec_ready = 1'b1;
    Icache_valid_out = 1'b0;
    repeat (6) tick();
    chk("t4_addr_hold", 64'(proc2Icache_addr), 64'h108);
    Icache_valid_out = 1'b1;
    repeat (4) tick();

    // 5: seven held, simultaneous dequeue makes room
    dec_ready = 1'b0;
    do_redirect(64'h4);
    repeat (4) tick();
    chk("t5_count7", 64'(fq_count), 64'd7);
    dec_ready = 1'b1;
    tick();
    chk("t5_count8", 64'(fq_count), 64'd8);
    dec_ready = 1'b0;
    do_redirect(64'h4);
    repeat (4) tick();
    tick();
    chk("t5_noacc_count", 64'(fq_count), 64'd7);
    chk("t5_noacc_addr", 64'(proc2Icache_addr), 64'h20);

    // 6: halt drains, redirect resumes, async reset mid-fill
    dec_ready = 1'b1;
    halt = 1'b1;
    repeat (12) tick();
    chk("t6_drained", 64'(fq_count), 64'd0);
    halt = 1'b0;
    repeat (2) tick();
    chk("t6_halt_hold", 64'(fq_count), 64'd0);
    do_redirect(64'h40);
    chk("t6_addr40", 64'(proc2Icache_addr), 64'h40);
    dec_ready = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_addr", 64'(proc2Icache_addr), 64'd0);
    chk("t6_rst_valid", 64'(if_valid), 64'd0);
    chk("t6_rst_count", 64'(fq_count), 64'd0);
    chk("t6_rst_inst", 64'(if_inst), 64'd0);
    chk("t6_rst_pc", 64'(if_pc), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    dec_ready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
